image_mem_arbiter: RTL
======================

Name: image_mem_arbiter

Overview:
- Shares one single-port synchronous image RAM (4096 x 12-bit, 64x64 image) between two requesters.
- Requester 1 is the VGA pixel fetch path (display reads); requester 2 is a writer (image loader / watermark updater).
- Display reads have absolute priority. Writes are buffered in a small FIFO and drained into idle RAM cycles, so image content can change at runtime without corrupting the pixel stream.

Parameters:
- ADDR_W, 12, RAM address width (4096 pixels).
- DATA_W, 12, pixel width (12-bit RGB).
- FIFO_DEPTH, 4, write FIFO entries; power of two, at least 2.

Ports:
- CLK  in  1  pixel-domain clock.
- RST_N  in  1  asynchronous active-low reset.
- DISP_REQ  in  1  display read request, one read per cycle it is high.
- DISP_ADDR  in  ADDR_W  display read address.
- DISP_DATA  out  DATA_W  read pixel.
- DISP_VALID  out  1  DISP_DATA valid strobe.
- BLANK  in  1  display is in blanking interval.
- WR_VALID  in  1  writer has a word.
- WR_READY  out  1  FIFO can accept.
- WR_ADDR  in  ADDR_W  write address.
- WR_DATA  in  DATA_W  write pixel.
- MEM_ADDR  out  ADDR_W  RAM address (registered).
- MEM_WE  out  1  RAM write enable (registered).
- MEM_WDATA  out  DATA_W  RAM write data (registered).
- MEM_RDATA  in  DATA_W  RAM read data, valid 1 cycle after the address is presented.
- OVERRUN  out  1  sticky: WR_VALID seen while WR_READY was low.
- WR_COUNT  out  16  committed-write counter.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO empty; WR_READY goes 1 on the first cycle after release; OVERRUN 0; WR_COUNT 0; any in-flight read is discarded, so no DISP_VALID follows.
- Write acceptance: a word is pushed when WR_VALID && WR_READY at a CLK edge.
  - WR_READY = (fifo_count < FIFO_DEPTH), taken from registered count only.
  - A pop in the same cycle does not make a full FIFO accept (no combinational pass-through).
- Grant, evaluated each cycle (grant state GNT_IDLE / GNT_RD / GNT_WR, registered):
  - DISP_REQ=1 -> GNT_RD: next-cycle MEM_ADDR=DISP_ADDR, MEM_WE=0.
  - Else if FIFO non-empty and write-drain allowed -> GNT_WR: next-cycle MEM_ADDR/MEM_WDATA = FIFO head, MEM_WE=1; pop head; WR_COUNT+1 (wraps at 16'hFFFF -> 0).
  - Else GNT_IDLE: MEM_WE=0, MEM_ADDR holds its previous value.
- Write-drain allowed: always, unless the optional feature is enabled.
- Read latency, fixed at 3 cycles:
  - Cycle N: DISP_REQ sampled.
  - N+1: MEM_ADDR presented.
  - N+2: MEM_RDATA returned.
  - N+3: DISP_DATA registered and DISP_VALID=1.
  - Back-to-back requests give back-to-back valids, full throughput.
- DISP_DATA holds its last value when DISP_VALID=0.
- Read/write same address, write earlier: a read granted after a write to the same address returns the new data (RAM is write-first for the sequential case). No forwarding from FIFO contents: a read while the write is still queued returns old data.
- FIFO ordering strictly in order; pointers wrap modulo FIFO_DEPTH.
- OVERRUN set when WR_VALID=1 && WR_READY=0; cleared only by reset. The offered word is not stored.
- Simultaneous push and pop with FIFO non-full: count unchanged, both occur.

Optional Feature:
- Macro: WR_BLANK_ONLY_EN
- Defined: write-drain allowed only while BLANK=1 (tear-free updates). Writes queue during active video, and WR_READY drops when the FIFO is full.
- Undefined: BLANK is ignored; writes drain in any cycle with DISP_REQ=0.

Test Plan:
- Reset then DISP_REQ pulse with DISP_ADDR=12'h041 and RAM[0x041]=12'hABC -> DISP_VALID exactly 3 cycles later, DISP_DATA=12'hABC; OVERRUN=0, WR_COUNT=0.
- DISP_REQ held high 10 cycles while WR_VALID pushes 4 words -> WR_READY low after the 4th, no MEM_WE during requests; after DISP_REQ falls, 4 writes in 4 consecutive cycles, in order; WR_COUNT=4.
- Write 12'h123 to 0x000, let it drain, then read 0x000 -> DISP_DATA=12'h123.
- FIFO full with WR_VALID=1 -> OVERRUN=1 and stays 1 after the FIFO drains; the dropped word is never written.
- WR_BLANK_ONLY_EN defined: DISP_REQ=0, BLANK=0, 2 queued writes -> no MEM_WE; BLANK=1 -> 2 writes issued.
- Assert RST_N low mid-stream with 3 reads in flight and FIFO half full -> outputs 0 immediately; no DISP_VALID and no MEM_WE after release until new requests arrive.

Source files
------------

// File: rtl/image_mem_arbiter.sv
// Single-port image RAM arbiter: display reads win, writes queue in a FIFO.
// Define WR_BLANK_ONLY_EN to drain queued writes only while BLANK is high.
module image_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              DISP_REQ,
  input  logic [ADDR_W-1:0] DISP_ADDR,
  output logic [DATA_W-1:0] DISP_DATA,
  output logic              DISP_VALID,
  input  logic              BLANK,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              OVERRUN,
  output logic [15:0]       WR_COUNT
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_RD,
    GNT_WR
  } gnt_e;

  gnt_e gnt_q, gnt_d;

  logic [ADDR_W-1:0] fa_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fd_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              live_q;

  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic              mwe_q, mwe_d;
  logic              rv1_q, dvalid_q;
  logic [DATA_W-1:0] ddata_q;
  logic              ov_q;
  logic [15:0]       wcnt_q;

  logic push, pop, full, empty, drain_ok;

`ifdef WR_BLANK_ONLY_EN
  assign drain_ok = BLANK;
`else
  // BLANK has no effect in this build
  assign drain_ok = BLANK | 1'b1;
`endif

  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign WR_READY = live_q && !full;
  assign push     = WR_VALID && WR_READY;
  assign cnt_d    = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) gnt_q <= GNT_IDLE;
    else        gnt_q <= gnt_d;
  end

  always_comb begin
    gnt_d = GNT_IDLE;
    unique case (1'b1)
      DISP_REQ:                      gnt_d = GNT_RD;
      (!DISP_REQ && !empty && drain_ok): gnt_d = GNT_WR;
      default:                       gnt_d = GNT_IDLE;
    endcase
  end

  always_comb begin
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwe_d    = 1'b0;
    pop      = 1'b0;
    unique case (gnt_d)
      GNT_RD: maddr_d = DISP_ADDR;
      GNT_WR: begin
        maddr_d  = fa_q[rp_q];
        mwdata_d = fd_q[rp_q];
        mwe_d    = 1'b1;
        pop      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fa_q[wp_q] <= WR_ADDR;
      fd_q[wp_q] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      live_q   <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwe_q    <= 1'b0;
      rv1_q    <= 1'b0;
      dvalid_q <= 1'b0;
      ddata_q  <= '0;
      ov_q     <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      live_q   <= 1'b1;
      cnt_q    <= cnt_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwe_q    <= mwe_d;
      if (push) wp_q <= wp_q + PW'(1);
      if (pop) begin
        rp_q   <= rp_q + PW'(1);
        wcnt_q <= wcnt_q + 16'd1;
      end
      if (WR_VALID && !WR_READY) ov_q <= 1'b1;
      // RAM data lands one cycle after the address stage
      rv1_q    <= (gnt_q == GNT_RD);
      dvalid_q <= rv1_q;
      if (rv1_q) ddata_q <= MEM_RDATA;
    end
  end

  assign MEM_ADDR   = maddr_q;
  assign MEM_WE     = mwe_q;
  assign MEM_WDATA  = mwdata_q;
  assign DISP_VALID = dvalid_q;
  assign DISP_DATA  = ddata_q;
  assign OVERRUN    = ov_q;
  assign WR_COUNT   = wcnt_q;

endmodule
